// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the cpu run-control block: FSM state and host command encodings.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CPURST = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_HALT  = 2'd3
    } cmd_op_t;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program memory for the cpu: one synchronous write port, one combinational read port.
module cpu_prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array is deliberately not reset, so it stays a plain RAM and a
    // loaded program survives a run-control reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control for the cpu core: reset/run/step/halt sequencing, one address
// breakpoint, a saturating executed-cycle counter and the program-load port.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    output logic              cmd_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_n_rst,
    output logic              cpu_en,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             resume_q, resume_d;
    logic             cmd_err_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_fire;
    logic             bp_hit;
    cmd_op_t          op;

    assign op       = cmd_op_t'(cmd_op);
    assign cmd_fire = cmd_valid && cmd_ready;
    // The resume flag lets a halted-at-breakpoint program execute past that address.
    assign bp_hit   = bp_en && (cpu_addr == bp_addr) && !resume_q;

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        cmd_err_d = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        cpu_n_rst = 1'b1;
        cpu_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cpu_n_rst = 1'b0;
                cmd_ready = 1'b1;
                wr_ready  = 1'b1;
                if (cmd_fire) begin
                    case (op)
                        CMD_RUN:   state_d = ST_CPURST;
                        CMD_RESET: state_d = ST_IDLE;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_CPURST: begin
                cpu_n_rst = 1'b0;
                resume_d  = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cmd_ready = 1'b1;
                cpu_en    = !bp_hit;
                resume_d  = 1'b0;
                if (bp_hit) begin
                    state_d = ST_HALT;
                end
                if (cmd_fire) begin
                    case (op)
                        CMD_HALT:  state_d = ST_HALT;
                        CMD_RESET: state_d = ST_IDLE;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            ST_HALT: begin
                cmd_ready = 1'b1;
                wr_ready  = 1'b1;
                if (cmd_fire) begin
                    case (op)
                        CMD_RUN: begin
                            state_d  = ST_RUN;
                            resume_d = 1'b1;
                        end
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_RESET: state_d = ST_IDLE;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end
            default: begin
                cpu_n_rst = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            resume_q <= 1'b0;
            cmd_err  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cmd_err  <= cmd_err_d;
            if (state_q == ST_CPURST) begin
                cnt_q <= '0;
            end else if (cpu_en && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cnt_q;

    // A write racing a reset is dropped.
    cpu_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_valid && wr_ready && n_rst),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (cpu_addr),
        .rdata (cpu_data)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a 4-bit cycle counter so saturation is reachable.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic              cmd_err;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              bp_en = 1'b0;
    logic [ADDR_W-1:0] bp_addr = '0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_n_rst;
    logic              cpu_en;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] prog [4];

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_err   (cmd_err),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_n_rst (cpu_n_rst),
        .cpu_en    (cpu_en),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input cmd_op_t op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        #1;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
        tests++; if (cpu_n_rst !== 1'b0 || cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu n_rst=%b en=%b exp 0/0", cpu_n_rst, cpu_en); end
        tests++; if (cycle_cnt !== 4'd0 || cmd_err !== 1'b0) begin fails++; $display("FAIL reset_cnt cnt=%0d err=%b exp 0/0", cycle_cnt, cmd_err); end
        tests++; if (cmd_ready !== 1'b1 || wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready cmd=%b wr=%b exp 1/1", cmd_ready, wr_ready); end
    endtask

    task automatic test_mem_write();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(i);
            wr_data  = prog[i];
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = ADDR_W'(i);
            #1;
            tests++; if (cpu_data !== prog[i]) begin fails++; $display("FAIL mem_read addr=%0d got=%h exp=%h", i, cpu_data, prog[i]); end
        end
        cpu_addr = 4'd2;
    endtask

    task automatic test_run_count();
        send_cmd(CMD_RUN);
        tests++; if (state !== 3'd1 || cpu_n_rst !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL cpurst state=%0d n_rst=%b rdy=%b exp 1/0/0", state, cpu_n_rst, cmd_ready); end
        tick();
        tests++; if (state !== 3'd2 || cpu_n_rst !== 1'b1 || cpu_en !== 1'b1 || cycle_cnt !== 4'd0) begin fails++; $display("FAIL run_entry state=%0d n_rst=%b en=%b cnt=%0d exp 2/1/1/0", state, cpu_n_rst, cpu_en, cycle_cnt); end
        wr_valid = 1'b1;
        wr_addr  = 4'd2;
        wr_data  = 8'hff;
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL run_wr_ready got=%b exp=0", wr_ready); end
        for (int i = 0; i < 9; i++) begin
            tick();
            wr_valid = 1'b0;
        end
        send_cmd(CMD_HALT);
        tests++; if (state !== 3'd4 || cpu_en !== 1'b0 || cycle_cnt !== 4'd10) begin fails++; $display("FAIL halt state=%0d en=%b cnt=%0d exp 4/0/10", state, cpu_en, cycle_cnt); end
        tests++; if (cpu_data !== 8'h33) begin fails++; $display("FAIL run_write_blocked got=%h exp=33", cpu_data); end
        tick();
        tick();
        tests++; if (cycle_cnt !== 4'd10) begin fails++; $display("FAIL halt_hold cnt=%0d exp=10", cycle_cnt); end
    endtask

    task automatic test_step();
        for (int i = 0; i < 3; i++) begin
            send_cmd(CMD_STEP);
            tests++; if (state !== 3'd3 || cpu_en !== 1'b1 || cmd_ready !== 1'b0 || wr_ready !== 1'b0) begin fails++; $display("FAIL step%0d state=%0d en=%b rdy=%b wr=%b exp 3/1/0/0", i, state, cpu_en, cmd_ready, wr_ready); end
            tick();
            tests++; if (state !== 3'd4 || cpu_en !== 1'b0 || cycle_cnt !== 4'(11 + i)) begin fails++; $display("FAIL step%0d_back state=%0d en=%b cnt=%0d exp 4/0/%0d", i, state, cpu_en, cycle_cnt, 11 + i); end
        end
        send_cmd(CMD_HALT);
        tests++; if (cmd_err !== 1'b1 || state !== 3'd4) begin fails++; $display("FAIL halt_in_halt err=%b state=%0d exp 1/4", cmd_err, state); end
        tick();
        tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL err_pulse got=%b exp=0", cmd_err); end
    endtask

    task automatic test_breakpoint();
        send_cmd(CMD_RESET);
        tests++; if (state !== 3'd0 || cycle_cnt !== 4'd13) begin fails++; $display("FAIL halt_reset state=%0d cnt=%0d exp 0/13", state, cycle_cnt); end
        bp_en    = 1'b1;
        bp_addr  = 4'd5;
        cpu_addr = 4'd3;
        send_cmd(CMD_RUN);
        tick();
        tick();
        cpu_addr = 4'd4;
        tick();
        cpu_addr = 4'd5;
        #1;
        tests++; if (cpu_en !== 1'b0 || cycle_cnt !== 4'd2) begin fails++; $display("FAIL bp_hit en=%b cnt=%0d exp 0/2", cpu_en, cycle_cnt); end
        tick();
        tests++; if (state !== 3'd4 || cycle_cnt !== 4'd2) begin fails++; $display("FAIL bp_halt state=%0d cnt=%0d exp 4/2", state, cycle_cnt); end
        send_cmd(CMD_RUN);
        tests++; if (state !== 3'd2 || cpu_en !== 1'b1) begin fails++; $display("FAIL bp_resume state=%0d en=%b exp 2/1", state, cpu_en); end
        tick();
        cpu_addr = 4'd6;
        #1;
        tests++; if (state !== 3'd2 || cpu_en !== 1'b1 || cycle_cnt !== 4'd3) begin fails++; $display("FAIL bp_past state=%0d en=%b cnt=%0d exp 2/1/3", state, cpu_en, cycle_cnt); end
        tick();
        cpu_addr = 4'd5;
        #1;
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL bp_rehit en=%b exp=0", cpu_en); end
        tick();
        tests++; if (state !== 3'd4 || cycle_cnt !== 4'd4) begin fails++; $display("FAIL bp_rehalt state=%0d cnt=%0d exp 4/4", state, cycle_cnt); end
        cpu_addr = 4'd6;
        send_cmd(CMD_RUN);
        tick();
        cpu_addr  = 4'd5;
        cmd_valid = 1'b1;
        cmd_op    = CMD_HALT;
        #1;
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL bp_and_halt en=%b exp=0", cpu_en); end
        tick();
        cmd_valid = 1'b0;
        tests++; if (state !== 3'd4 || cycle_cnt !== 4'd5 || cmd_err !== 1'b0) begin fails++; $display("FAIL bp_and_halt_end state=%0d cnt=%0d err=%b exp 4/5/0", state, cycle_cnt, cmd_err); end
        bp_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_cmd(CMD_STEP);
        n_rst = 1'b0;
        tick();
        tests++; if (state !== 3'd0 || cpu_n_rst !== 1'b0 || cycle_cnt !== 4'd0) begin fails++; $display("FAIL rst_in_step state=%0d n_rst=%b cnt=%0d exp 0/0/0", state, cpu_n_rst, cycle_cnt); end
        n_rst = 1'b1;
        send_cmd(CMD_RUN);
        tick();
        tick();
        tick();
        tick();
        tests++; if (state !== 3'd2 || cycle_cnt !== 4'd3) begin fails++; $display("FAIL rerun state=%0d cnt=%0d exp 2/3", state, cycle_cnt); end
        n_rst = 1'b0;
        tick();
        tests++; if (state !== 3'd0 || cpu_n_rst !== 1'b0 || cycle_cnt !== 4'd0) begin fails++; $display("FAIL rst_in_run state=%0d n_rst=%b cnt=%0d exp 0/0/0", state, cpu_n_rst, cycle_cnt); end
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = ADDR_W'(i);
            #1;
            tests++; if (cpu_data !== prog[i]) begin fails++; $display("FAIL mem_kept addr=%0d got=%h exp=%h", i, cpu_data, prog[i]); end
        end
        send_cmd(CMD_STEP);
        tests++; if (cmd_err !== 1'b1 || state !== 3'd0) begin fails++; $display("FAIL step_in_idle err=%b state=%0d exp 1/0", cmd_err, state); end
    endtask

    task automatic test_saturation();
        send_cmd(CMD_RUN);
        tick();
        repeat (20) tick();
        tests++; if (cycle_cnt !== 4'd15) begin fails++; $display("FAIL sat_run cnt=%0d exp=15", cycle_cnt); end
        send_cmd(CMD_HALT);
        tick();
        tests++; if (state !== 3'd4 || cycle_cnt !== 4'd15) begin fails++; $display("FAIL sat_halt state=%0d cnt=%0d exp 4/15", state, cycle_cnt); end
    endtask

    initial begin
        prog[0] = 8'h11;
        prog[1] = 8'h22;
        prog[2] = 8'h33;
        prog[3] = 8'h44;
        test_reset();
        test_mem_write();
        test_run_count();
        test_step();
        test_breakpoint();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
